// File: rtl/uart_pkg.sv
// Shared state encoding and parameter limits for the framed UART receiver.
// UART_RX_PARITY_EN adds the PARITY state to the enumeration.
package uart_pkg;

   localparam int CLKS_PER_BIT_DEF = 434;
   localparam int CLKS_PER_BIT_MIN = 4;
   localparam int DATA_BITS_DEF    = 8;
   localparam int DATA_BITS_MIN    = 5;
   localparam int DATA_BITS_MAX    = 9;
   localparam int STOP_BITS_DEF    = 1;
   localparam int STOP_BITS_MIN    = 1;
   localparam int STOP_BITS_MAX    = 2;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
      PARITY    = 3'd3,
`endif
      STOP      = 3'd4,
      WAIT_HIGH = 3'd5
   } rx_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle (high) level.
module uart_sync2 (
   input  logic i_Clock,
   input  logic i_rst,
   input  logic i_async,
   output logic o_sync
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = i_async;
      sync_d = meta_q;
   end

   always_ff @(posedge i_Clock) begin
      if (i_rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign o_sync = sync_q;

endmodule

// File: rtl/uart_rx_framed.sv
// Framed UART receiver with framing, parity and break detection.
// Define UART_RX_PARITY_EN to expect one parity bit after the data bits.
//
// state     | meaning
// IDLE      | line idle, waiting for a low level
// START     | confirming the start bit at mid-bit
// DATA      | sampling data bits mid-bit, LSB first
// PARITY    | sampling the parity bit (UART_RX_PARITY_EN only)
// STOP      | sampling stop bit(s), then reporting the frame or a break
// WAIT_HIGH | after a break or framing error, waiting for the line to go high
module uart_rx_framed
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int DATA_BITS    = DATA_BITS_DEF,
   parameter int STOP_BITS    = STOP_BITS_DEF
) (
   input  logic                 i_Clock,
   input  logic                 i_rst,
   input  logic                 i_Rx_Serial,
   input  logic                 i_Parity_Odd,
   output logic                 o_Rx_DV,
   output logic [DATA_BITS-1:0] o_Rx_Byte,
   output logic                 o_Frame_Err,
   output logic                 o_Parity_Err,
   output logic                 o_Break
);

   if (CLKS_PER_BIT < CLKS_PER_BIT_MIN) begin : g_bad_clks_per_bit
      $error("uart_rx_framed: CLKS_PER_BIT=%0d is below %0d", CLKS_PER_BIT, CLKS_PER_BIT_MIN);
   end
   if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
      $error("uart_rx_framed: DATA_BITS=%0d outside %0d..%0d", DATA_BITS, DATA_BITS_MIN, DATA_BITS_MAX);
   end
   if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
      $error("uart_rx_framed: STOP_BITS=%0d outside %0d..%0d", STOP_BITS, STOP_BITS_MIN, STOP_BITS_MAX);
   end

   localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]  HALF_CNT  = CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CNT_W-1:0]  BIT_CNT   = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0]        DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);

   logic rx_s;

   uart_sync2 u_sync (
      .i_Clock (i_Clock),
      .i_rst   (i_rst),
      .i_async (i_Rx_Serial),
      .o_sync  (rx_s)
   );

   rx_state_e            state_q, state_d;
   logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
   logic [3:0]           bits_left_q, bits_left_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 any_one_q, any_one_d;
   logic                 stop_bad_q, stop_bad_d;
   logic                 rx_dv_q, rx_dv_d;
   logic [DATA_BITS-1:0] rx_byte_q, rx_byte_d;
   logic                 frame_err_q, frame_err_d;
   logic                 brk_q, brk_d;
   logic                 bit_tick;
`ifdef UART_RX_PARITY_EN
   logic                 par_bad_q, par_bad_d;
   logic                 parity_err_q, parity_err_d;
`else
   logic                 unused_parity_odd;
   assign unused_parity_odd = i_Parity_Odd;
`endif

   // Down-counter: terminal count 0 marks the mid-bit sampling point.
   assign bit_tick = (clk_cnt_q == '0);

   always_comb begin
      state_d     = state_q;
      clk_cnt_d   = clk_cnt_q;
      bits_left_d = bits_left_q;
      shift_d     = shift_q;
      any_one_d   = any_one_q;
      stop_bad_d  = stop_bad_q;
      rx_byte_d   = rx_byte_q;
      rx_dv_d     = 1'b0;
      frame_err_d = 1'b0;
      brk_d       = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d    = par_bad_q;
      parity_err_d = 1'b0;
`endif

      case (state_q)
         IDLE: begin
            bits_left_d = '0;
            any_one_d   = 1'b0;
            stop_bad_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_d   = 1'b0;
`endif
            if (!rx_s) begin
               state_d   = START;
               clk_cnt_d = HALF_CNT;
            end else begin
               clk_cnt_d = '0;
            end
         end

         START: begin
            if (!bit_tick) begin
               clk_cnt_d = clk_cnt_q - 1'b1;
            end else if (!rx_s) begin
               state_d     = DATA;
               clk_cnt_d   = BIT_CNT;
               bits_left_d = DATA_LAST;
            end else begin
               state_d   = IDLE;
               clk_cnt_d = '0;
            end
         end

         DATA: begin
            if (!bit_tick) begin
               clk_cnt_d = clk_cnt_q - 1'b1;
            end else begin
               clk_cnt_d = BIT_CNT;
               shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
               any_one_d = any_one_q | rx_s;
               if (bits_left_q != '0) begin
                  bits_left_d = bits_left_q - 4'd1;
               end else begin
`ifdef UART_RX_PARITY_EN
                  state_d     = PARITY;
`else
                  state_d     = STOP;
                  bits_left_d = STOP_LAST;
`endif
               end
            end
         end

`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (!bit_tick) begin
               clk_cnt_d = clk_cnt_q - 1'b1;
            end else begin
               clk_cnt_d   = BIT_CNT;
               par_bad_d   = ((^shift_q) ^ rx_s) != i_Parity_Odd;
               any_one_d   = any_one_q | rx_s;
               state_d     = STOP;
               bits_left_d = STOP_LAST;
            end
         end
`endif

         STOP: begin
            if (!bit_tick) begin
               clk_cnt_d = clk_cnt_q - 1'b1;
            end else if (bits_left_q != '0) begin
               clk_cnt_d   = BIT_CNT;
               bits_left_d = bits_left_q - 4'd1;
               stop_bad_d  = stop_bad_q | ~rx_s;
               any_one_d   = any_one_q | rx_s;
            end else begin
               clk_cnt_d = '0;
               // An all-zero frame is a break: report it instead of data and keep the old byte.
               if (!(any_one_q || rx_s)) begin
                  brk_d   = 1'b1;
                  state_d = WAIT_HIGH;
               end else begin
                  rx_dv_d     = 1'b1;
                  rx_byte_d   = shift_q;
                  frame_err_d = stop_bad_q | ~rx_s;
`ifdef UART_RX_PARITY_EN
                  parity_err_d = par_bad_q;
`endif
                  state_d = (stop_bad_q || !rx_s) ? WAIT_HIGH : IDLE;
               end
            end
         end

         WAIT_HIGH: begin
            clk_cnt_d = '0;
            if (rx_s) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d   = IDLE;
            clk_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge i_Clock) begin
      if (i_rst) begin
         state_q     <= IDLE;
         clk_cnt_q   <= '0;
         bits_left_q <= '0;
         shift_q     <= '0;
         any_one_q   <= 1'b0;
         stop_bad_q  <= 1'b0;
         rx_dv_q     <= 1'b0;
         rx_byte_q   <= '0;
         frame_err_q <= 1'b0;
         brk_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         clk_cnt_q   <= clk_cnt_d;
         bits_left_q <= bits_left_d;
         shift_q     <= shift_d;
         any_one_q   <= any_one_d;
         stop_bad_q  <= stop_bad_d;
         rx_dv_q     <= rx_dv_d;
         rx_byte_q   <= rx_byte_d;
         frame_err_q <= frame_err_d;
         brk_q       <= brk_d;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= par_bad_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign o_Rx_DV     = rx_dv_q;
   assign o_Rx_Byte   = rx_byte_q;
   assign o_Frame_Err = frame_err_q;
   assign o_Break     = brk_q;
`ifdef UART_RX_PARITY_EN
   assign o_Parity_Err = parity_err_q;
`else
   assign o_Parity_Err = 1'b0;
`endif

endmodule

// File: doc/uart_rx_framed.md
UART_RX_FRAMED -- requirements
Module: uart_rx_framed

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clocks per UART bit (legal range >= 4).
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (legal range 5..9).
REQ-003 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame (legal values 1 or 2).
REQ-004 SHALL have port i_Clock  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst  in  1  reset; synchronous, active-high.
REQ-006 SHALL have port i_Rx_Serial  in  1  asynchronous serial line; idle high.
REQ-007 SHALL have port i_Parity_Odd  in  1  parity sense: 1 = odd, 0 = even; static during a frame.
REQ-008 SHALL have port o_Rx_DV  out  1  one-cycle frame-complete strobe.
REQ-009 SHALL have port o_Rx_Byte  out  DATA_BITS  received data, LSB first on the line.
REQ-010 SHALL have port o_Frame_Err  out  1  stop bit sampled low; qualified by o_Rx_DV.
REQ-011 SHALL have port o_Parity_Err  out  1  parity mismatch; qualified by o_Rx_DV.
REQ-012 SHALL have port o_Break  out  1  one-cycle break-detected strobe.

Function
REQ-013 SHALL pass i_Rx_Serial through a two-flop synchroniser; all sampling uses the second flop output (rx_s).
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-015 IDLE: clear the bit counter and clock counter, and move to START on rx_s == 0.
REQ-016 START: at clock count (CLKS_PER_BIT-1)/2, go to DATA with count cleared if rx_s == 0, else go to IDLE as a glitch, with no outputs.
REQ-017 DATA: sample rx_s into bit[index] every CLKS_PER_BIT clocks (mid-bit); after DATA_BITS samples, go to PARITY if parity is compiled in, else to STOP.
REQ-018 PARITY: sample one bit mid-bit; parity error = (XOR of data bits XOR sampled bit) != i_Parity_Odd.
REQ-019 STOP: sample STOP_BITS bits mid-bit; frame error if any sampled stop bit is 0.
REQ-020 The frame result SHALL register on the cycle after the final stop sample: o_Rx_DV = 1 for exactly one cycle, with o_Rx_Byte, o_Frame_Err and o_Parity_Err valid in that same cycle.
REQ-021 Break: if all data bits, the parity bit (if present) and the stop bit(s) are 0, pulse o_Break for one cycle instead of o_Rx_DV, and leave o_Rx_Byte unchanged.
REQ-022 After a break or frame error, SHALL enter WAIT_HIGH and remain there until rx_s == 1, then go to IDLE.
REQ-023 After a good frame, SHALL return directly to IDLE, so that a back-to-back start bit following the half stop bit is received without loss.
REQ-024 o_Rx_Byte SHALL hold its value until the next o_Rx_DV; o_Frame_Err and o_Parity_Err SHALL be 0 whenever o_Rx_DV is 0.
REQ-025 The clock counter width SHALL be $clog2(CLKS_PER_BIT); the counter SHALL never wrap within a bit.
REQ-026 Illegal parameter values SHALL cause an elaboration-time error.

Reset
REQ-027 While i_rst is high: state = IDLE, counters = 0, synchroniser flops = 1, o_Rx_Byte = 0, and all strobes and error outputs = 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no o_Rx_DV or o_Break, and reception SHALL resume from IDLE on the first cycle with i_rst low.

Configuration
REQ-029 Macro UART_RX_PARITY_EN defined: the PARITY state is present, and one parity bit follows the data bits.
REQ-030 Macro UART_RX_PARITY_EN undefined: no PARITY state, i_Parity_Odd is ignored, and o_Parity_Err is tied to 0.

Structure
REQ-031 Package uart_pkg SHALL hold the state enumeration, the legal DATA_BITS and STOP_BITS limits, and the default CLKS_PER_BIT.
REQ-032 The synchroniser SHALL be a sub-module uart_sync2 (reset value 1, active-high synchronous reset); all other logic lives in uart_rx_framed.

Verification
REQ-033 CLKS_PER_BIT=16, DATA_BITS=8, no parity, send 0xA5 with a good stop -> one o_Rx_DV pulse, o_Rx_Byte=0xA5, o_Frame_Err=0.
REQ-034 UART_RX_PARITY_EN defined, i_Parity_Odd=0, send 0x07 with parity bit 0 -> o_Rx_DV pulse with o_Parity_Err=1; repeat with parity bit 1 -> o_Parity_Err=0.
REQ-035 Send 0x3C with the stop bit held 0 for one bit, then line high -> o_Rx_DV pulse with o_Frame_Err=1; the next frame 0x55 is received correctly.
REQ-036 Hold the line low for 20 bit times -> exactly one o_Break pulse and no o_Rx_DV; the block stays in WAIT_HIGH until the line goes high, then receives 0x81 correctly.
REQ-037 Drive a 5-clock low glitch on the idle line -> no outputs; then send 0x12 and 0x34 back-to-back with STOP_BITS=2 -> two o_Rx_DV pulses with the correct bytes.
REQ-038 Assert i_rst at data bit 4 of a frame -> no o_Rx_DV, o_Rx_Byte=0; release reset and send 0xFF -> o_Rx_Byte=0xFF.
